// File: rtl/eth_hdr_parser_qinq_if.sv
// Stream input and metadata handshake bundle for eth_hdr_parser_qinq.
interface eth_hdr_parser_qinq_if #(
   parameter int DATA_BYTES = 4
);
   logic [8*DATA_BYTES-1:0] s_tdata;
   logic                    s_tvalid;
   logic                    s_tlast;
   logic                    s_tready;
   logic                    m_meta_valid;
   logic                    m_meta_ready;

   modport master (output s_tdata, s_tvalid, s_tlast, m_meta_ready,
                   input  s_tready, m_meta_valid);
   modport slave  (input  s_tdata, s_tvalid, s_tlast, m_meta_ready,
                   output s_tready, m_meta_valid);
endinterface

// File: rtl/eth_hdr_parser_qinq.sv
// Ethernet L2 header parser with stacked VLAN (QinQ) support.
// Optional statistics counters are enabled with macro ETH_PARSER_STATS_EN.
module eth_hdr_parser_qinq #(
   parameter int DATA_BYTES = 4,
   parameter int MAX_TAGS   = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   eth_hdr_parser_qinq_if.slave bus,
   output logic [47:0] dest_mac,
   output logic [47:0] src_mac,
   output logic [15:0] ethertype,
   output logic [2:0]  vlan_count,
   output logic [11:0] outer_vid,
   output logic [11:0] inner_vid,
   output logic [4:0]  l2_header_len,
   output logic        is_ipv4,
   output logic        is_ipv6,
   output logic        is_arp,
   output logic        is_unknown,
`ifdef ETH_PARSER_STATS_EN
   output logic [31:0] stat_frames,
   output logic [31:0] stat_runts,
   output logic [31:0] stat_vlan_frames,
`endif
   output logic        runt_err
);
   typedef enum logic [1:0] {ST_HDR = 2'd0, ST_HOLD = 2'd1, ST_DRAIN = 2'd2} state_t;

   typedef struct packed {
      logic [47:0] dmac;
      logic [47:0] smac;
      logic [15:0] etype;
      logic [2:0]  vlan_count;
      logic [11:0] outer_vid;
      logic [11:0] inner_vid;
      logic [4:0]  hdr_len;
      logic        ipv4;
      logic        ipv6;
      logic        arp;
      logic        unknown;
      logic        runt;
   } meta_t;

   function automatic logic [3:0] classify(input logic [15:0] etype);
      case (etype)
         16'h0800: classify = 4'b1000;
         16'h86DD: classify = 4'b0100;
         16'h0806: classify = 4'b0010;
         default:  classify = 4'b0001;
      endcase
   endfunction

   state_t      r_state, w_state_nxt;
   meta_t       r_meta, w_meta_nxt;
   logic [4:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
   logic [5:0]  w_sum, w_off, w_base, w_rel;
   logic [7:0]  r_type_hi, w_type_hi_nxt, w_byte;
   logic [3:0]  r_tci_hi, w_tci_hi_nxt;
   logic [15:0] w_type;
   logic [11:0] w_vid;
   logic        w_done, w_cplt, w_accept, r_last, r_meta_valid;

   assign w_accept         = bus.s_tvalid && bus.s_tready;
   assign bus.s_tready     = (r_state != ST_HOLD);
   assign bus.m_meta_valid = r_meta_valid;

   // Byte-serial header walk over the accepted beat; the type field moves 4 bytes per parsed tag
   always_comb begin
      w_meta_nxt    = r_meta;
      w_type_hi_nxt = r_type_hi;
      w_tci_hi_nxt  = r_tci_hi;
      w_done        = 1'b0;
      w_cplt        = 1'b0;
      w_off         = 6'd0;
      w_base        = 6'd12;
      w_rel         = 6'd0;
      w_byte        = 8'd0;
      w_type        = 16'd0;
      w_vid         = 12'd0;
      w_sum         = {1'b0, r_cnt} + 6'(DATA_BYTES);
      w_cnt_inc     = (w_sum > 6'd31) ? 5'd31 : w_sum[4:0];
      if (w_accept) begin
         w_cnt_nxt = bus.s_tlast ? 5'd0 : w_cnt_inc;
      end else begin
         w_cnt_nxt = r_cnt;
      end
      if ((r_state == ST_HDR) && w_accept) begin
         for (int b = 0; b < DATA_BYTES; b++) begin
            w_off  = {1'b0, r_cnt} + 6'(b);
            w_byte = bus.s_tdata[8*b +: 8];
            w_base = 6'd12 + {1'b0, w_meta_nxt.vlan_count, 2'b00};
            w_rel  = w_off - w_base;
            if (!w_done) begin
               for (int k = 0; k < 6; k++) begin
                  w_meta_nxt.dmac[8*(5-k) +: 8] = (w_off == 6'(k))     ? w_byte : w_meta_nxt.dmac[8*(5-k) +: 8];
                  w_meta_nxt.smac[8*(5-k) +: 8] = (w_off == 6'(k + 6)) ? w_byte : w_meta_nxt.smac[8*(5-k) +: 8];
               end
               // Offsets below the type field wrap to large w_rel values and fall to default
               case (w_rel)
                  6'd0: w_type_hi_nxt = w_byte;
                  6'd1: begin
                     w_type = {w_type_hi_nxt, w_byte};
                     if (((w_type == 16'h8100) || (w_type == 16'h88A8)) &&
                         (w_meta_nxt.vlan_count < 3'(MAX_TAGS))) begin
                        w_done = 1'b0;
                     end else begin
                        w_done                = 1'b1;
                        w_meta_nxt.etype      = w_type;
                        {w_meta_nxt.ipv4, w_meta_nxt.ipv6, w_meta_nxt.arp, w_meta_nxt.unknown} = classify(w_type);
                        w_meta_nxt.hdr_len    = 5'd14 + {w_meta_nxt.vlan_count, 2'b00};
                     end
                  end
                  6'd2: w_tci_hi_nxt = w_byte[3:0];
                  6'd3: begin
                     w_vid = {w_tci_hi_nxt, w_byte};
                     if (w_meta_nxt.vlan_count == 3'd0) begin
                        w_meta_nxt.outer_vid = w_vid;
                     end else begin
                        w_meta_nxt.outer_vid = w_meta_nxt.outer_vid;
                     end
                     w_meta_nxt.inner_vid  = w_vid;
                     w_meta_nxt.vlan_count = w_meta_nxt.vlan_count + 3'd1;
                  end
                  default: w_done = 1'b0;
               endcase
            end else begin
               w_done = 1'b1;
            end
         end
         if (!w_done && bus.s_tlast) begin
            w_meta_nxt.runt    = 1'b1;
            w_meta_nxt.unknown = 1'b1;
            w_meta_nxt.hdr_len = w_cnt_inc;
         end else begin
            w_meta_nxt.runt    = w_meta_nxt.runt;
         end
         w_cplt = w_done || bus.s_tlast;
      end else if ((r_state == ST_HOLD) && bus.m_meta_ready) begin
         w_meta_nxt    = '0;
         w_type_hi_nxt = 8'd0;
         w_tci_hi_nxt  = 4'd0;
      end else begin
         w_cplt = 1'b0;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_HDR: begin
            if (w_cplt) w_state_nxt = ST_HOLD;
            else        w_state_nxt = ST_HDR;
         end
         ST_HOLD: begin
            if (bus.m_meta_ready) w_state_nxt = r_last ? ST_HDR : ST_DRAIN;
            else                  w_state_nxt = ST_HOLD;
         end
         ST_DRAIN: begin
            if (w_accept && bus.s_tlast) w_state_nxt = ST_HDR;
            else                         w_state_nxt = ST_DRAIN;
         end
         default: w_state_nxt = ST_HDR;
      endcase
   end

   // State, metadata and parse-context registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_HDR;
         r_meta       <= '0;
         r_cnt        <= 5'd0;
         r_type_hi    <= 8'd0;
         r_tci_hi     <= 4'd0;
         r_last       <= 1'b0;
         r_meta_valid <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_meta       <= w_meta_nxt;
         r_cnt        <= w_cnt_nxt;
         r_type_hi    <= w_type_hi_nxt;
         r_tci_hi     <= w_tci_hi_nxt;
         r_last       <= w_cplt ? bus.s_tlast : r_last;
         r_meta_valid <= (w_state_nxt == ST_HOLD);
      end
   end

`ifdef ETH_PARSER_STATS_EN
   logic [31:0] r_stat_frames, r_stat_runts, r_stat_vlan;

   // Saturating per-acceptance statistics
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stat_frames <= 32'd0;
         r_stat_runts  <= 32'd0;
         r_stat_vlan   <= 32'd0;
      end else if ((r_state == ST_HOLD) && bus.m_meta_ready) begin
         if (r_stat_frames != 32'hFFFF_FFFF) r_stat_frames <= r_stat_frames + 32'd1;
         if (r_meta.runt && (r_stat_runts != 32'hFFFF_FFFF)) r_stat_runts <= r_stat_runts + 32'd1;
         if ((r_meta.vlan_count != 3'd0) && (r_stat_vlan != 32'hFFFF_FFFF)) r_stat_vlan <= r_stat_vlan + 32'd1;
      end
   end

   assign stat_frames      = r_stat_frames;
   assign stat_runts       = r_stat_runts;
   assign stat_vlan_frames = r_stat_vlan;
`endif

   assign dest_mac      = r_meta.dmac;
   assign src_mac       = r_meta.smac;
   assign ethertype     = r_meta.etype;
   assign vlan_count    = r_meta.vlan_count;
   assign outer_vid     = r_meta.outer_vid;
   assign inner_vid     = r_meta.inner_vid;
   assign l2_header_len = r_meta.hdr_len;
   assign is_ipv4       = r_meta.ipv4;
   assign is_ipv6       = r_meta.ipv6;
   assign is_arp        = r_meta.arp;
   assign is_unknown    = r_meta.unknown;
   assign runt_err      = r_meta.runt;
endmodule
